// File: rtl/alif_spike_decoder.sv
// Decodes an ALIF neuron spike train into per-window spike rate and last inter-spike interval,
// presented one result per window over a valid/ready handshake with a sticky overrun flag.
module alif_spike_decoder #(
    parameter int unsigned WINDOW_LEN = 1000,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ISI_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             out_ready,
    input  logic             clear_ovr,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_rate,
    output logic [ISI_W-1:0] out_isi,
    output logic             out_ovr
);

    localparam int unsigned WIN_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               spike_q;
    logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
    logic [CNT_W-1:0]   spike_cnt, spike_cnt_nxt;
    logic [ISI_W-1:0]   isi_timer, isi_timer_nxt;
    logic [ISI_W-1:0]   last_isi, last_isi_nxt;
    logic               out_valid_nxt;
    logic [CNT_W-1:0]   out_rate_nxt;
    logic [ISI_W-1:0]   out_isi_nxt;
    logic               out_ovr_nxt;

    logic               spike_edge;
    logic               win_end;
    logic               handshake;
    logic               overrun;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ISI_W-1:0]   isi_inc;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            spike_q   <= 1'b0;
            win_cnt   <= '0;
            spike_cnt <= '0;
            isi_timer <= '0;
            last_isi  <= '0;
            out_valid <= 1'b0;
            out_rate  <= '0;
            out_isi   <= '0;
            out_ovr   <= 1'b0;
        end else begin
            state     <= state_nxt;
            spike_q   <= spike_in;
            win_cnt   <= win_cnt_nxt;
            spike_cnt <= spike_cnt_nxt;
            isi_timer <= isi_timer_nxt;
            last_isi  <= last_isi_nxt;
            out_valid <= out_valid_nxt;
            out_rate  <= out_rate_nxt;
            out_isi   <= out_isi_nxt;
            out_ovr   <= out_ovr_nxt;
        end
    end

    // Next-state, windowing, ISI qualification and handshake
    always_comb begin
        state_nxt     = state;
        win_cnt_nxt   = win_cnt;
        spike_cnt_nxt = spike_cnt;
        isi_timer_nxt = isi_timer;
        last_isi_nxt  = last_isi;
        out_valid_nxt = out_valid;
        out_rate_nxt  = out_rate;
        out_isi_nxt   = out_isi;
        out_ovr_nxt   = out_ovr;

        spike_edge = spike_in & ~spike_q & ena;
        win_end    = ena & (win_cnt == WIN_LAST);
        handshake  = out_valid & out_ready;
        overrun    = win_end & out_valid & ~out_ready;
        cnt_inc    = (spike_cnt == CNT_MAX) ? CNT_MAX : spike_cnt + CNT_W'(1);
        isi_inc    = (isi_timer == ISI_MAX) ? ISI_MAX : isi_timer + ISI_W'(1);

        if (ena) begin
            win_cnt_nxt = (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (spike_edge) begin
                    state_nxt     = ONE;
                    isi_timer_nxt = ISI_W'(1);
                end
            end
            ONE, RUN: begin
                if (spike_edge) begin
                    state_nxt     = RUN;
                    last_isi_nxt  = isi_timer;
                    isi_timer_nxt = ISI_W'(1);
                end else if (ena) begin
                    isi_timer_nxt = isi_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (spike_edge) begin
            spike_cnt_nxt = cnt_inc;
        end

        // A window end both publishes the result and restarts the count
        if (win_end) begin
            out_rate_nxt  = spike_edge ? cnt_inc : spike_cnt;
            out_isi_nxt   = (state_nxt == RUN) ? last_isi_nxt : '0;
            spike_cnt_nxt = '0;
            out_valid_nxt = 1'b1;
        end else if (handshake) begin
            out_valid_nxt = 1'b0;
        end

        if (overrun) begin
            out_ovr_nxt = 1'b1;
        end else if (clear_ovr) begin
            out_ovr_nxt = 1'b0;
        end
    end

endmodule

// File: doc/alif_spike_decoder.md
Name: alif_spike_decoder

Overview:
- Receive-side companion to the single-channel ALIF neuron: consumes the neuron's spike output and decodes it into numeric rate and inter-spike-interval (ISI) measurements.
- Counts spike rising edges over a fixed window and tracks the most recent ISI.
- Presents one result per window over a valid/ready handshake, so a readout/serialiser stage can drain results at its own pace.
- Sits between the neuron's spike output and the chip-level output mux/readout logic.

Parameters:
- WINDOW_LEN, 1000, window length in clock cycles. Legal range is ≥ 2.
- CNT_W, 8, width of the spike-count result. The count saturates.
- ISI_W, 16, width of the ISI timer and result. The ISI saturates.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- rst, input, 1, asynchronous, active-high reset.
- ena, input, 1, measurement enable. Low freezes windowing and ISI timing.
- spike_in, input, 1, neuron spike level, synchronous to clk. May stay high for more than one cycle.
- out_ready, input, 1, consumer accepts the result.
- clear_ovr, input, 1, synchronous clear of the sticky overrun flag.
- out_valid, output, 1, result available.
- out_rate, output, CNT_W, spike edges counted in the completed window.
- out_isi, output, ISI_W, last measured ISI in cycles. Reads 0 until two edges have been seen.
- out_ovr, output, 1, sticky flag: a result was overwritten before it was accepted.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - All registers clear.
  - out_valid=0, out_rate=0, out_isi=0, out_ovr=0.
  - State=IDLE.
  - spike_q=0, win_cnt=0, spike_cnt=0, isi_timer=0.
- Edge detect:
  - spike_q <= spike_in on every cycle, independent of ena.
  - edge = spike_in & ~spike_q & ena.
  - A level held for N cycles produces one edge. Re-enabling ena while spike_in is high produces no edge.
- State machine (ISI qualification):
  - IDLE: no edge seen since reset. On an edge, go to ONE and set isi_timer <= 1.
  - ONE: on an edge, last_isi <= isi_timer, set isi_timer <= 1, and go to RUN.
  - RUN: on an edge, last_isi <= isi_timer and set isi_timer <= 1. Stay in RUN.
  - In ONE and RUN, isi_timer increments by 1 on each ena cycle without an edge, saturating at 2^ISI_W-1.
  - With edges at cycles t0 and t1, captured ISI = t1-t0, or the saturated maximum.
- Window counter:
  - While ena=1, win_cnt counts 0..WINDOW_LEN-1 and wraps.
  - On each edge, spike_cnt increments, saturating at 2^CNT_W-1.
  - Window end is the ena=1 cycle with win_cnt==WINDOW_LEN-1. On that cycle:
    - out_rate <= sat(spike_cnt + edge).
    - out_isi <= last_isi, including an ISI captured in the same cycle; 0 if state≠RUN.
    - spike_cnt <= 0.
    - out_valid <= 1. The result is visible one cycle after the window-end cycle.
- ena=0: win_cnt, spike_cnt, isi_timer and state hold. The handshake and clear_ovr stay active.
- Handshake:
  - out_valid stays high and out_rate/out_isi stay stable until out_valid & out_ready.
  - On the following cycle out_valid=0, unless a window end coincides.
  - out_ready while out_valid=0 is ignored.
- Simultaneous events:
  - Window end and handshake in the same cycle: the new result loads, out_valid stays 1, no overrun.
  - Window end while out_valid=1 and no handshake that cycle: the result is overwritten and out_ovr <= 1.
  - clear_ovr in the same cycle as an overrun event: set wins, out_ovr=1.
  - Otherwise clear_ovr drives out_ovr to 0 on the next cycle.
- Reset mid-window or mid-handshake: everything clears immediately. The partial window is discarded and no result is emitted.

Test Plan:
All scenarios use WINDOW_LEN=16, CNT_W=4, ISI_W=6.
- Reset, ena=1, no spikes, out_ready=1 → out_valid pulses for 1 cycle every 16 cycles with out_rate=0, out_isi=0; out_ovr=0.
- Single-cycle spikes at window cycles 2, 7, 12, out_ready=1 → out_rate=3, out_isi=5, state RUN. A spike held high for 4 cycles counts as 1.
- 20 spikes in a window at edge spacing 0/1 (alternating levels is impossible past 8, so verify with 8 edges at spacing 2) → out_rate=8. Force CNT_W=2 with the same stimulus → out_rate=3 (saturated).
- Edges 70 cycles apart → out_isi=63 (saturated). Window-end cycle coinciding with an edge → that edge is counted in the closing window and its ISI appears in out_isi.
- out_ready=0 across two window ends → out_ovr=1 and out_valid stays high with the second window's data. Raise out_ready → one handshake, then out_valid=0. Pulse clear_ovr → out_ovr=0.
- Drop ena for 10 cycles mid-window with spike_in toggling → no counts and win_cnt frozen. Result arrives 10 cycles late. Assert rst mid-window → outputs 0 immediately and the next result arrives exactly 16 enabled cycles after release.
